// File: rtl/cdb_arbiter_pkg.sv
// Shared CDB arbiter types: default geometry, bus packet and helpers.
// CDB_BYPASS_EN (optional) lets an empty FU FIFO forward its input in the same cycle.
package cdb_arbiter_pkg;

  localparam int NUM_FU_DEF    = 6;
  localparam int WAYS_DEF      = 3;
  localparam int XLEN_DEF      = 32;
  localparam int PRF_DEF       = 64;
  localparam int ROB_DEF       = 16;
  localparam int BUF_DEPTH_DEF = 2;

  localparam int CDB_LANE_IDX_W = $clog2(WAYS_DEF);
  localparam int FU_IDX_W       = $clog2(NUM_FU_DEF);

  typedef struct packed {
    logic                       valid;
    logic [$clog2(PRF_DEF)-1:0] prf_idx;
    logic [XLEN_DEF-1:0]        data;
    logic [$clog2(ROB_DEF)-1:0] rob_idx;
  } CDB_PACKET;

  function automatic int wrap_inc(input int v, input int n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/cdb_result_fifo.sv
// Per-FU result buffer: circular store with wrapping head/tail and a count.
// flush empties it synchronously and wins over a same-edge push.
module cdb_result_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 2
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  logic [W-1:0] din,
  output logic [W-1:0] head,
  output logic         empty,
  output logic         full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] hd_q, hd_d;
  logic [AW-1:0] tl_q, tl_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CW'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem_q[hd_q];

  always_comb begin
    hd_d  = hd_q;
    tl_d  = tl_q;
    cnt_d = cnt_q;
    if (flush) begin
      hd_d  = '0;
      tl_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) tl_d = tl_q + AW'(1);
      if (do_pop)  hd_d = hd_q + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   cnt_d = cnt_q + CW'(1);
        2'b01:   cnt_d = cnt_q - CW'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hd_q  <= '0;
      tl_q  <= '0;
      cnt_q <= '0;
    end else begin
      hd_q  <= hd_d;
      tl_q  <= tl_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push && !flush) mem_q[tl_q] <= din;
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: per-FU result FIFOs, round-robin grant of up to
// WAYS heads per cycle, registered lanes. CDB_BYPASS_EN enables empty-FIFO forwarding.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int NUM_FU    = NUM_FU_DEF,
  parameter int WAYS      = WAYS_DEF,
  parameter int XLEN      = XLEN_DEF,
  parameter int PRF       = PRF_DEF,
  parameter int ROB       = ROB_DEF,
  parameter int BUF_DEPTH = BUF_DEPTH_DEF
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic                                 squash,
  input  logic [NUM_FU-1:0]                    fu_valid,
  input  logic [NUM_FU-1:0][XLEN-1:0]          fu_data,
  input  logic [NUM_FU-1:0][$clog2(PRF)-1:0]   fu_prf_idx,
  input  logic [NUM_FU-1:0][$clog2(ROB)-1:0]   fu_rob_idx,
  output logic [NUM_FU-1:0]                    fu_ready,
  output logic [WAYS-1:0]                      CDB_valid,
  output logic [WAYS-1:0][$clog2(PRF)-1:0]     CDB_PRF_idx,
  output logic [WAYS-1:0][XLEN-1:0]            CDB_Data,
  output logic [WAYS-1:0][$clog2(ROB)-1:0]     CDB_rob_idx
);

  localparam int PW   = $clog2(PRF);
  localparam int RW   = $clog2(ROB);
  localparam int EW   = PW + XLEN + RW;
  localparam int PTRW = $clog2(NUM_FU);

  typedef struct packed {
    logic            valid;
    logic [PW-1:0]   prf;
    logic [XLEN-1:0] data;
    logic [RW-1:0]   rob;
  } lane_t;

  logic [NUM_FU-1:0]         empty, full, push, pop, cand, byp;
  logic [NUM_FU-1:0][EW-1:0] din, head, src;
  lane_t [WAYS-1:0]          lane_d, lane_q;
  logic [PTRW-1:0]           rr_q, rr_d;

  for (genvar i = 0; i < NUM_FU; i++) begin : g_fu
    assign din[i] = {fu_prf_idx[i], fu_data[i], fu_rob_idx[i]};

    cdb_result_fifo #(
      .W     (EW),
      .DEPTH (BUF_DEPTH)
    ) u_fifo (
      .clock (clock),
      .reset (reset),
      .push  (push[i]),
      .pop   (pop[i]),
      .flush (squash),
      .din   (din[i]),
      .head  (head[i]),
      .empty (empty[i]),
      .full  (full[i])
    );

`ifdef CDB_BYPASS_EN
    assign src[i] = empty[i] ? din[i] : head[i];
`else
    assign src[i] = head[i];
`endif
  end

`ifdef CDB_BYPASS_EN
  assign cand = ~empty | fu_valid;
`else
  assign cand = ~empty;
`endif

  assign fu_ready = ~full;
  assign push     = fu_valid & ~full & ~byp & {NUM_FU{~squash}};

  // Rotate from rr_q; the k-th candidate found lands on lane k.
  always_comb begin
    int  n;
    int  idx;
    int  last;
    logic any;
    lane_d = '0;
    pop    = '0;
    byp    = '0;
    n      = 0;
    last   = 0;
    any    = 1'b0;
    for (int j = 0; j < NUM_FU; j++) begin
      idx = int'(rr_q) + j;
      if (idx >= NUM_FU) idx = idx - NUM_FU;
      if (cand[idx] && n < WAYS) begin
        lane_d[n] = {1'b1, src[idx]};
        pop[idx]  = !empty[idx];
        byp[idx]  = empty[idx];
        last      = idx;
        any       = 1'b1;
        n         = n + 1;
      end
    end
    rr_d = any ? PTRW'(wrap_inc(last, NUM_FU)) : rr_q;
    if (squash) begin
      lane_d = '0;
      rr_d   = rr_q;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      lane_q <= '0;
      rr_q   <= '0;
    end else begin
      lane_q <= lane_d;
      rr_q   <= rr_d;
    end
  end

  for (genvar w = 0; w < WAYS; w++) begin : g_lane
    assign CDB_valid[w]   = lane_q[w].valid;
    assign CDB_PRF_idx[w] = lane_q[w].prf;
    assign CDB_Data[w]    = lane_q[w].data;
    assign CDB_rob_idx[w] = lane_q[w].rob;
  end

endmodule
